// File: rtl/led_flow_ctrl_if.sv
// Configuration and LED drive bundle for led_flow_ctrl; carries pwm_duty only
// when LED_FLOW_PWM_EN is defined. dbg_* expose the latched configuration.
interface led_flow_ctrl_if #(
    parameter int LED_NUM = 4,
    parameter int LVL_W   = 3
);
    // cfg_vld is a valid-only strobe with no ready: every strobed cycle is
    // accepted, latches cfg_mode/cfg_level and restarts the pattern.
    logic               cfg_vld;
    logic [1:0]         cfg_mode;
    logic [LVL_W-1:0]   cfg_level;
`ifdef LED_FLOW_PWM_EN
    logic [3:0]         pwm_duty;
`endif
    logic [LED_NUM-1:0] led;
    logic               step_tick;
    logic               busy;
    logic [1:0]         dbg_mode;
    logic [LVL_W-1:0]   dbg_lvl;

`ifdef LED_FLOW_PWM_EN
    modport master (output cfg_vld, cfg_mode, cfg_level, pwm_duty,
                    input  led, step_tick, busy, dbg_mode, dbg_lvl);
    modport slave  (input  cfg_vld, cfg_mode, cfg_level, pwm_duty,
                    output led, step_tick, busy, dbg_mode, dbg_lvl);
`else
    modport master (output cfg_vld, cfg_mode, cfg_level,
                    input  led, step_tick, busy, dbg_mode, dbg_lvl);
    modport slave  (input  cfg_vld, cfg_mode, cfg_level,
                    output led, step_tick, busy, dbg_mode, dbg_lvl);
`endif
endinterface

// File: rtl/led_flow_ctrl.sv
// LED pattern engine: OFF / BAR / ROTATE / BOUNCE at a STEP_CNT-cycle interval.
// Optional PWM dimming of the output is enabled by defining LED_FLOW_PWM_EN.
module led_flow_ctrl #(
    parameter int LED_NUM  = 4,
    parameter int LVL_W    = 3,
    parameter int STEP_CNT = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    led_flow_ctrl_if.slave bus
);
    localparam int PW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STEP_CNT - 1);
    localparam logic [LVL_W-1:0] LED_NUM_L = LVL_W'(LED_NUM);
    localparam logic [PW-1:0]    POS_MAX   = PW'(LED_NUM - 1);

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_BAR = 2'd1,
        MODE_ROT = 2'd2,
        MODE_BNC = 2'd3
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [LED_NUM-1:0] pat_q, pat_d;
    logic               busy_q, busy_d;
    logic [LVL_W-1:0]   lvl_clamp;
    logic               tick;

    function automatic logic [LED_NUM-1:0] bar_mask(input logic [LVL_W-1:0] len);
        logic [LED_NUM-1:0] m;
        m = '0;
        for (int i = 0; i < LED_NUM; i++) m[i] = (LVL_W'(i) < len);
        return m;
    endfunction

    function automatic logic [LED_NUM-1:0] one_hot(input logic [PW-1:0] pos);
        logic [LED_NUM-1:0] m;
        m = '0;
        for (int i = 0; i < LED_NUM; i++) m[i] = (PW'(i) == pos);
        return m;
    endfunction

    function automatic logic [LED_NUM-1:0] rotl(input logic [LED_NUM-1:0] p);
        logic [LED_NUM-1:0] m;
        m = '0;
        for (int i = 0; i < LED_NUM; i++) m[i] = p[(i + LED_NUM - 1) % LED_NUM];
        return m;
    endfunction

    assign lvl_clamp = (bus.cfg_level > LED_NUM_L) ? LED_NUM_L : bus.cfg_level;
    assign tick      = busy_q && (cnt_q == CNT_MAX);

    always_comb begin
        mode_d = mode_q;
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        pos_d  = pos_q;
        pat_d  = pat_q;
        busy_d = busy_q;
        // A load always wins over a coincident terminal count.
        if (bus.cfg_vld) begin
            mode_d = mode_e'(bus.cfg_mode);
            lvl_d  = lvl_clamp;
            cnt_d  = '0;
            dir_d  = 1'b0;
            pos_d  = '0;
            busy_d = bus.cfg_mode[1];
            case (mode_e'(bus.cfg_mode))
                MODE_OFF: pat_d = '0;
                MODE_BAR: pat_d = bar_mask(lvl_clamp);
                MODE_ROT: pat_d = bar_mask((lvl_clamp == '0) ? LVL_W'(1) : lvl_clamp);
                default:  pat_d = one_hot('0);
            endcase
        end else if (busy_q) begin
            if (tick) begin
                cnt_d = '0;
                if (mode_q == MODE_ROT) begin
                    pat_d = rotl(pat_q);
                end else begin
                    // Direction flips on the edge that reaches an end, so ends dwell one step.
                    if (LED_NUM == 1) begin
                        pos_d = '0;
                    end else if (!dir_q) begin
                        pos_d = pos_q + 1'b1;
                        if (pos_d == POS_MAX) dir_d = 1'b1;
                    end else begin
                        pos_d = pos_q - 1'b1;
                        if (pos_d == '0) dir_d = 1'b0;
                    end
                    pat_d = one_hot(pos_d);
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= MODE_OFF;
            lvl_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            pos_q  <= '0;
            pat_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            pos_q  <= pos_d;
            pat_q  <= pat_d;
            busy_q <= busy_d;
        end
    end

    assign bus.step_tick = tick;
    assign bus.busy      = busy_q;
    assign bus.dbg_mode  = mode_q;
    assign bus.dbg_lvl   = lvl_q;

`ifdef LED_FLOW_PWM_EN
    logic [3:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 4'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) pwm_cnt_q <= 4'd0;
        else            pwm_cnt_q <= pwm_cnt_d;
    end

    assign bus.led = pat_q & {LED_NUM{pwm_cnt_q < bus.pwm_duty}};
`else
    assign bus.led = pat_q;
`endif
endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl (LED_NUM=4, STEP_CNT=4) with an expected
// queue of per-cycle {busy, step_tick, led} checked by a negedge monitor.
module tb_led_flow_ctrl;
    localparam int LED_NUM  = 4;
    localparam int LVL_W    = 3;
    localparam int STEP_CNT = 4;
    localparam int CNT_W    = 3;
    localparam logic [1:0] M_OFF = 2'd0, M_BAR = 2'd1, M_ROT = 2'd2, M_BNC = 2'd3;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   tests     = 0;
    int   fails     = 0;
    int   cyc       = 0;
    logic [5:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    led_flow_ctrl_if #(.LED_NUM(LED_NUM), .LVL_W(LVL_W)) bus ();

    led_flow_ctrl #(
        .LED_NUM(LED_NUM), .LVL_W(LVL_W), .STEP_CNT(STEP_CNT), .CNT_W(CNT_W)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus.slave)
    );

`ifdef LED_FLOW_PWM_EN
    logic [3:0] pwm_model;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) pwm_model <= 4'd0;
        else            pwm_model <= pwm_model + 4'd1;
    end
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: one expected entry per cycle, compared away from the active edge.
    always @(negedge sys_clk) begin
        logic [5:0]         e;
        logic [LED_NUM-1:0] el;
        cyc++;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            el = e[3:0];
`ifdef LED_FLOW_PWM_EN
            if (!(pwm_model < bus.pwm_duty)) el = '0;
`endif
            chk("led", 32'(bus.led), 32'(el));
            chk("busy", 32'(bus.busy), 32'(e[5]));
            chk("step_tick", 32'(bus.step_tick), 32'(e[4]));
        end
    end

    // Called at posedge+1: applies inputs and queues what this cycle must show.
    task automatic drive(input logic vld, input logic [1:0] mode, input logic [LVL_W-1:0] lvl,
                         input logic [3:0] eled, input logic ebusy, input logic etick);
        bus.cfg_vld   = vld;
        bus.cfg_mode  = mode;
        bus.cfg_level = lvl;
        exp_q.push_back({ebusy, etick, eled});
        @(posedge sys_clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] eled, input logic ebusy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, M_BNC, 3'd7, eled, ebusy, 1'b0);
    endtask

    task automatic step(input logic [3:0] eled);
        hold(eled, 1'b1, STEP_CNT - 1);
        drive(1'b0, M_OFF, 3'd0, eled, 1'b1, 1'b1);
    endtask

    initial begin
        bus.cfg_vld   = 1'b0;
        bus.cfg_mode  = M_OFF;
        bus.cfg_level = '0;
`ifdef LED_FLOW_PWM_EN
        bus.pwm_duty  = 4'd15;
`endif
        repeat (2) @(posedge sys_clk);
        #1;
        chk("reset_led", 32'(bus.led), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_tick", 32'(bus.step_tick), 32'd0);
        sys_rst_n = 1'b1;

        hold(4'b0000, 1'b0, 10);

        drive(1'b1, M_BAR, 3'd3, 4'b0000, 1'b0, 1'b0);
        hold(4'b0111, 1'b0, 50);
        drive(1'b1, M_BAR, 3'd7, 4'b0111, 1'b0, 1'b0);
        hold(4'b1111, 1'b0, 5);

        drive(1'b1, M_ROT, 3'd1, 4'b1111, 1'b0, 1'b0);
        step(4'b0001); step(4'b0010); step(4'b0100); step(4'b1000); step(4'b0001);
        drive(1'b1, M_ROT, 3'd2, 4'b0010, 1'b1, 1'b0);
        step(4'b0011); step(4'b0110); step(4'b1100); step(4'b1001);

        drive(1'b1, M_BNC, 3'd0, 4'b0011, 1'b1, 1'b0);
        step(4'b0001); step(4'b0010); step(4'b0100); step(4'b1000);
        step(4'b0100); step(4'b0010); step(4'b0001); step(4'b0010);

        // Reload BOUNCE at the right end with the counter at 2.
        step(4'b0100);
        hold(4'b1000, 1'b1, 2);
        drive(1'b1, M_BNC, 3'd0, 4'b1000, 1'b1, 1'b0);
        step(4'b0001); step(4'b0010);

        // Load coincident with terminal count: no step applied.
        hold(4'b0100, 1'b1, STEP_CNT - 1);
        drive(1'b1, M_ROT, 3'd3, 4'b0100, 1'b1, 1'b1);
        step(4'b0111); step(4'b1110);

        // Asynchronous reset mid-ROTATE.
        hold(4'b1101, 1'b1, 2);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(bus.led), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_tick", 32'(bus.step_tick), 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        hold(4'b0000, 1'b0, 3);

        drive(1'b1, M_ROT, 3'd0, 4'b0000, 1'b0, 1'b0);
        step(4'b0001);
        drive(1'b1, M_OFF, 3'd5, 4'b0010, 1'b1, 1'b0);
        hold(4'b0000, 1'b0, 8);

`ifdef LED_FLOW_PWM_EN
        bus.pwm_duty = 4'd4;
`endif
        drive(1'b1, M_BAR, 3'd4, 4'b0000, 1'b0, 1'b0);
        hold(4'b1111, 1'b0, 32);

        @(negedge sys_clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/led_flow_ctrl.md
Name: led_flow_ctrl

Overview:
Parametrised LED pattern engine driving an LED_NUM-wide bar from a latched configuration (mode + level). It supports static bar, rotating bar and single-dot bounce modes at a programmable step interval. It sits behind the front-end state/decoder stage, which issues configuration strobes. This block is the generalised successor of the fixed 4-LED flow controller.

Parameters:
LED_NUM, 4, number of LEDs driven; legal range 1..32.
LVL_W, 3, width of level port; must satisfy 2**LVL_W > LED_NUM.
STEP_CNT, 25_000_000, sys_clk cycles per animation step (0.5 s at 50 MHz); minimum 2.
CNT_W, 25, step counter width; must satisfy 2**CNT_W >= STEP_CNT.

Ports:
sys_clk  in  1  system clock; all logic is on the rising edge.
sys_rst_n  in  1  asynchronous, active-low reset.
cfg_vld  in  1  single-cycle strobe that loads mode and level.
cfg_mode  in  2  0=OFF, 1=BAR, 2=ROTATE, 3=BOUNCE.
cfg_level  in  LVL_W  bar length for BAR/ROTATE; values above LED_NUM are clamped to LED_NUM.
led  out  LED_NUM  LED drive, active-high; bit 0 is the first LED.
step_tick  out  1  one-cycle pulse on each animation step.
busy  out  1  high while in an animated mode (ROTATE or BOUNCE).

Behaviour:
- Reset (async assert, sync release): led=0, step_tick=0, busy=0, mode_r=OFF, lvl_r=0, step counter=0, dir=0 (up), pos=0.
- Config load: when cfg_vld=1 at an edge, mode_r and the clamped lvl_r are latched. At the same edge:
  - the step counter clears to 0;
  - dir clears to up;
  - led is loaded with the initial pattern, visible in the next cycle.
- Every cfg_vld restarts the pattern, including when the values are unchanged.
- cfg_mode/cfg_level are ignored when cfg_vld=0.
- Initial patterns (L = clamped level):
  - OFF: all LEDs 0.
  - BAR: low L bits set.
  - ROTATE: low max(L,1) bits set.
  - BOUNCE: bit 0 only, with pos=0.
- Step counter, animated modes only:
  - Counts 0..STEP_CNT-1, then wraps.
  - step_tick is combinationally high while the counter equals STEP_CNT-1.
  - The pattern advances at that edge, so the first advance occurs exactly STEP_CNT cycles after the load edge.
- Step counter, OFF/BAR: the counter is held at 0, step_tick stays 0, and led is static.
- ROTATE step: led rotates left by one (bit LED_NUM-1 wraps to bit 0). If L >= LED_NUM, all LEDs are lit and the rotation is invisible.
- BOUNCE step: a single LED at index pos.
  - Moving up: pos+1. When pos reaches LED_NUM-1, dir flips in the same edge, so the next step is LED_NUM-2.
  - Moving down: mirror behaviour at 0.
  - End LEDs are lit for exactly one step (no double dwell).
  - Sequence for LED_NUM=4: 0,1,2,3,2,1,0,1...
  - For LED_NUM=1, pos stays 0 and the LED stays on.
- busy = (mode_r==ROTATE || mode_r==BOUNCE), registered with mode_r.
- Simultaneous cfg_vld and counter terminal count: the load wins. No step is applied and the counter goes to 0.
- Reset mid-animation: all state returns immediately to reset values.

Optional Feature:
Macro LED_FLOW_PWM_EN.
- Defined:
  - Adds input port pwm_duty (4 bits).
  - Adds a free-running 4-bit PWM counter, reset to 0.
  - Final output is led = pattern & {LED_NUM{pwm_cnt < pwm_duty}}.
  - duty 0 means all LEDs off; duty 15 means on 15 of every 16 cycles.
  - The pattern and stepping logic are unchanged.
- Undefined: no pwm_duty port, and led equals the pattern directly.

Test Plan:
1. Sim parameters LED_NUM=4, STEP_CNT=4. Release reset with no cfg_vld -> led=0000, busy=0, step_tick never asserts.
2. cfg_vld with mode=BAR, level=3 -> next cycle led=0111, static for 50 cycles. Then cfg_vld with level=7 -> led=1111 (clamped).
3. cfg_vld with mode=ROTATE, level=1 -> led=0001, then after 4 cycles 0010, then 0100, 1000, 0001; step_tick pulses once every 4 cycles and busy=1.
4. cfg_vld with mode=BOUNCE -> led steps through 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 at 4-cycle spacing.
5. In BOUNCE at led=1000, with the counter at 2, assert cfg_vld with BOUNCE -> led=0001, counter=0, dir up, and the next step occurs 4 cycles later. Also apply cfg_vld coincident with the terminal count -> no step applied.
6. Assert sys_rst_n low asynchronously mid-ROTATE -> led=0000 and busy=0 immediately. With LED_FLOW_PWM_EN defined, pwm_duty=4, BAR level=4 -> led=1111 for 4 of every 16 cycles, otherwise 0000.
